spi_flash_read_sequencer: RTL
=============================

Name: spi_flash_read_sequencer

Overview:
Sequences complete SPI flash READ transactions: command byte, 24-bit address, then N data bytes. It drives a byte-level SPI shift engine through a start/done handshake and owns flash chip select. Data bytes are returned to the 6809-side bus logic through a valid/ready handshake. It sits between the 6809 address-decode/register logic and the SPI byte engine.

Parameters:
READ_CMD, 8'h03, opcode sent as the first byte of every transaction
LEN_W, 8, width of the byte-count request field
CS_SETUP_CYC, 2, clk cycles flash_cs_n is low before the first xfer_start (min 1)
CS_HOLD_CYC, 2, clk cycles flash_cs_n is held high after a transaction before busy drops (min 1)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
req  in  1  start request, sampled only in IDLE
addr  in  24  flash byte address, latched on accepted req
len  in  LEN_W  number of data bytes, latched on accepted req
abort  in  1  terminate the current transaction
busy  out  1  high from the cycle after req is accepted until the cycle after done
done  out  1  one-cycle pulse at the end of a transaction (normal, aborted or len=0)
rd_data  out  8  received data byte
rd_valid  out  1  rd_data is valid
rd_ready  in  1  consumer accepts rd_data when rd_valid && rd_ready
xfer_start  out  1  one-cycle pulse: byte engine starts shifting xfer_tx
xfer_tx  out  8  byte to shift out, stable from xfer_start until xfer_done
xfer_done  in  1  one-cycle pulse: byte engine finished, xfer_rx valid this cycle
xfer_rx  in  8  byte shifted in by the engine
flash_cs_n  out  1  flash chip select, active low

Behaviour:
- Reset (rst_n=0 at a clk edge), from any state including mid-transaction: next state IDLE; flash_cs_n=1, busy=0, done=0, rd_valid=0, rd_data=8'h00, xfer_start=0, xfer_tx=8'h00; counters cleared. An xfer_done arriving after reset is ignored.
- States: IDLE, SETUP, CMD, ADR2, ADR1, ADR0, DATA, PRESENT, HOLD, FIN.
- IDLE: if req=1, latch addr and len. If len==0: go to FIN directly, flash_cs_n stays high, no xfer_start. Otherwise flash_cs_n<=0, busy<=1, go to SETUP.
- SETUP: count CS_SETUP_CYC cycles, then go to CMD.
- CMD/ADR2/ADR1/ADR0: on entry, pulse xfer_start for one cycle with xfer_tx = READ_CMD, addr[23:16], addr[15:8], addr[7:0] respectively. Wait for xfer_done, then advance. xfer_rx is discarded in these states.
- DATA: pulse xfer_start with xfer_tx=8'h00. On xfer_done: rd_data<=xfer_rx, rd_valid<=1, go to PRESENT.
- PRESENT: hold rd_data and rd_valid until rd_ready=1. On accept, rd_valid<=0 and the remaining count decrements. If remaining > 0, go to DATA; the next xfer_start comes the cycle after accept. If remaining = 0, flash_cs_n<=1 and go to HOLD. The next byte is never started before the current one is accepted; there is no overlap.
- HOLD: flash_cs_n high for CS_HOLD_CYC cycles, then go to FIN.
- FIN: done=1 for one cycle, then IDLE. busy drops the cycle after done.
- Byte count: an internal LEN_W-bit counter. len = 2^LEN_W-1 yields exactly that many bytes, with no wrap.
- abort:
  - In SETUP: go to HOLD immediately.
  - In CMD/ADRx/DATA with a byte in flight: finish the current byte, wait for xfer_done, discard xfer_rx, then go to HOLD. No rd_valid is raised.
  - In PRESENT: rd_valid drops the next cycle and the byte is discarded, even if rd_ready is high that same cycle. Go to HOLD.
  - Ignored in IDLE/HOLD/FIN.
- req while busy is ignored; there is no queue.
- xfer_done outside a wait state is ignored.
- Latency from req to first xfer_start = 1 + CS_SETUP_CYC cycles.

Test Plan:
1. Basic read: req, addr=24'h012345, len=2; engine model returns 8'hA5, 8'h5A with 3-cycle done latency, rd_ready=1. Required: xfer_tx sequence 03,01,23,45,00,00. rd_data A5 then 5A. flash_cs_n low from req+1 until after the second accept. done pulses once. busy falls the next cycle.
2. Backpressure: as scenario 1 with rd_ready low for 10 cycles per byte. Required: rd_valid/rd_data held stable and no xfer_start while stalled; each byte delivered exactly once.
3. len=0, addr=24'hFFFFFF. Required: no xfer_start; flash_cs_n stays high; done pulses 2 cycles after req.
4. Abort: len=4, abort asserted mid-ADR1 byte, then separately while PRESENT holds byte 2. Required: the in-flight byte completes; no further xfer_start; flash_cs_n high for CS_HOLD_CYC; done pulses once; no extra rd_valid.
5. Reset mid-DATA: rst_n=0 for 1 cycle while a byte is in flight; xfer_done arrives 2 cycles later. Required: all outputs at reset values the cycle after reset; stale xfer_done ignored; a new req runs a clean transaction.
6. Timing with CS_SETUP_CYC=3 and CS_HOLD_CYC=4. Required: exactly 3 cycles from flash_cs_n falling to the first xfer_start; exactly 4 high cycles before done; a req held high during busy is not re-accepted until IDLE.

Source files
------------

// File: rtl/spi_flash_read_sequencer.sv
// spi_flash_read_sequencer
//
// Runs complete SPI flash READ transactions for the 6809-side bus logic.
// A transaction is the READ opcode, a 24-bit address (MSB first) and then
// N data bytes. Each byte is handed to an external byte-level shift engine
// through a start/done handshake. Received data bytes go back to the bus
// logic one at a time through a valid/ready handshake. Flash chip select
// is owned here, with programmable setup and hold spacing.
//
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   req         start request, only looked at while idle
//   addr        flash byte address, captured when req is accepted
//   len         number of data bytes, captured when req is accepted
//   abort       ends the current transaction early
//   busy        transaction in progress
//   done        one-cycle pulse when a transaction ends (any reason)
//   rd_data     received data byte
//   rd_valid    rd_data holds a byte that has not yet been accepted
//   rd_ready    consumer takes rd_data when rd_valid && rd_ready
//   xfer_start  one-cycle pulse telling the engine to shift xfer_tx
//   xfer_tx     byte for the engine, stable until xfer_done
//   xfer_done   one-cycle pulse from the engine, xfer_rx valid with it
//   xfer_rx     byte shifted in by the engine
//   flash_cs_n  flash chip select, active low

module spi_flash_read_sequencer #(
    parameter logic [7:0] READ_CMD     = 8'h03,
    parameter int         LEN_W        = 8,
    parameter int         CS_SETUP_CYC = 2,
    parameter int         CS_HOLD_CYC  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             xfer_start,
    output logic [7:0]       xfer_tx,
    input  logic             xfer_done,
    input  logic [7:0]       xfer_rx,
    output logic             flash_cs_n
);

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] SETUP   = 4'd1;
    localparam logic [3:0] CMD     = 4'd2;
    localparam logic [3:0] ADR2    = 4'd3;
    localparam logic [3:0] ADR1    = 4'd4;
    localparam logic [3:0] ADR0    = 4'd5;
    localparam logic [3:0] DATA    = 4'd6;
    localparam logic [3:0] PRESENT = 4'd7;
    localparam logic [3:0] HOLD    = 4'd8;
    localparam logic [3:0] FIN     = 4'd9;

    // One shared counter times both the chip-select setup and hold gaps,
    // so it is sized for the longer of the two.
    localparam int CYC_MAX = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
    localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
    localparam logic [CYC_W-1:0] SETUP_LAST = CYC_W'(CS_SETUP_CYC - 1);
    localparam logic [CYC_W-1:0] HOLD_LAST  = CYC_W'(CS_HOLD_CYC - 1);

    logic [3:0]       state;
    logic [23:0]      addr_q;
    logic [LEN_W-1:0] remaining;
    logic [CYC_W-1:0] cyc_cnt;
    logic             abort_pend;
    logic             abort_any;
    logic             in_byte_wait;

    // An abort seen while a byte is in flight is remembered, because the
    // byte must still finish before the transaction is torn down.
    assign abort_any    = abort | abort_pend;
    assign in_byte_wait = (state == CMD) || (state == ADR2) || (state == ADR1) ||
                          (state == ADR0) || (state == DATA);

    // Main sequencer. Every output is registered. xfer_start and done are
    // pulses, so they default low each cycle and are raised only on the
    // transition that needs them. A transaction always leaves through HOLD
    // (chip select already high) and FIN (done pulse). FIN is also reached
    // straight from IDLE for a zero-length request. In that case done comes
    // one cycle later, so busy is still seen high for a cycle before done.
    // The byte counter is loaded with len and tested for one before it
    // decrements, so the full LEN_W range is usable without wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= 24'h000000;
            remaining  <= '0;
            cyc_cnt    <= '0;
            abort_pend <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_data    <= 8'h00;
            rd_valid   <= 1'b0;
            xfer_start <= 1'b0;
            xfer_tx    <= 8'h00;
            flash_cs_n <= 1'b1;
        end else begin
            xfer_start <= 1'b0;
            done       <= 1'b0;

            if (abort && in_byte_wait) begin
                abort_pend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    abort_pend <= 1'b0;
                    if (req) begin
                        addr_q    <= addr;
                        remaining <= len;
                        busy      <= 1'b1;
                        cyc_cnt   <= '0;
                        if (len == '0) begin
                            state <= FIN;
                        end else begin
                            flash_cs_n <= 1'b0;
                            state      <= SETUP;
                        end
                    end
                end

                SETUP: begin
                    if (abort) begin
                        flash_cs_n <= 1'b1;
                        cyc_cnt    <= '0;
                        state      <= HOLD;
                    end else if (cyc_cnt == SETUP_LAST) begin
                        cyc_cnt    <= '0;
                        xfer_start <= 1'b1;
                        xfer_tx    <= READ_CMD;
                        state      <= CMD;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                CMD, ADR2, ADR1, ADR0, DATA: begin
                    if (xfer_done) begin
                        if (abort_any) begin
                            flash_cs_n <= 1'b1;
                            cyc_cnt    <= '0;
                            state      <= HOLD;
                        end else if (state == DATA) begin
                            rd_data  <= xfer_rx;
                            rd_valid <= 1'b1;
                            state    <= PRESENT;
                        end else begin
                            xfer_start <= 1'b1;
                            case (state)
                                CMD:     begin xfer_tx <= addr_q[23:16]; state <= ADR2; end
                                ADR2:    begin xfer_tx <= addr_q[15:8];  state <= ADR1; end
                                ADR1:    begin xfer_tx <= addr_q[7:0];   state <= ADR0; end
                                default: begin xfer_tx <= 8'h00;         state <= DATA; end
                            endcase
                        end
                    end
                end

                PRESENT: begin
                    if (abort) begin
                        rd_valid   <= 1'b0;
                        flash_cs_n <= 1'b1;
                        cyc_cnt    <= '0;
                        state      <= HOLD;
                    end else if (rd_ready) begin
                        rd_valid  <= 1'b0;
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            flash_cs_n <= 1'b1;
                            cyc_cnt    <= '0;
                            state      <= HOLD;
                        end else begin
                            xfer_start <= 1'b1;
                            xfer_tx    <= 8'h00;
                            state      <= DATA;
                        end
                    end
                end

                HOLD: begin
                    if (cyc_cnt == HOLD_LAST) begin
                        cyc_cnt <= '0;
                        done    <= 1'b1;
                        state   <= FIN;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                FIN: begin
                    if (done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
